// File: rtl/instr_sequencer_pkg.sv
// Shared constants for the fetch/decode/execute sequencer: state codes,
// fault cause codes and instruction type bit positions.
package instr_sequencer_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_FETCH  = 3'd0;
    localparam logic [STATE_W-1:0] ST_DECODE = 3'd1;
    localparam logic [STATE_W-1:0] ST_EXEC   = 3'd2;
    localparam logic [STATE_W-1:0] ST_MEM    = 3'd3;
    localparam logic [STATE_W-1:0] ST_RETIRE = 3'd4;
    localparam logic [STATE_W-1:0] ST_FAULT  = 3'd5;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_ISEGV = 2'd1;
    localparam logic [1:0] CAUSE_DSEGV = 2'd2;
    localparam logic [1:0] CAUSE_ILL   = 2'd3;

    // Instruction word type bits: {is_pc, is_alu}
    localparam int IS_ALU_BIT = 0;
    localparam int IS_PC_BIT  = 1;

endpackage

// File: rtl/instr_sequencer_if.sv
// Sequencer boundary: MMU/decoder flags in, control pulses and status out.
// The slave modport is the sequencer; master is the surrounding control path.
interface instr_sequencer_if #(
    parameter int INSTR_W  = 32,
    parameter int RETIRE_W = 16,
    parameter int CAUSE_W  = 2
);
    logic [INSTR_W-1:0]  instruction;
    logic                instr_segv;
    logic                data_segv;
    logic                wait_instr;
    logic                wait_data;
    logic                dec_invalid;
    logic                dec_mem;
    logic                fault_clear;

    logic                ir_load;
    logic                exec_en;
    logic                mem_req;
    logic                pc_inc;
    logic                fault;
    logic [CAUSE_W-1:0]  fault_cause;
    logic [INSTR_W-1:0]  ir;
    logic [RETIRE_W-1:0] retired;

    modport master (
        output instruction, instr_segv, data_segv, wait_instr, wait_data,
               dec_invalid, dec_mem, fault_clear,
        input  ir_load, exec_en, mem_req, pc_inc, fault, fault_cause, ir, retired
    );

    modport slave (
        input  instruction, instr_segv, data_segv, wait_instr, wait_data,
               dec_invalid, dec_mem, fault_clear,
        output ir_load, exec_en, mem_req, pc_inc, fault, fault_cause, ir, retired
    );
endinterface

// File: rtl/instr_sequencer_seq_latency_counter.sv
// Loadable down-counter that times the EXEC phase. It parks at zero, and
// o_zero marks the final EXEC cycle.
module seq_latency_counter #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;

    // Load on EXEC entry, then count down to zero and hold there
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer. Pulses IR load, ALU enable,
// memory strobe and PC increment, captures fault causes and counts retires.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int INSTR_W  = 32,
    parameter int ALU_LAT  = 1,
    parameter int RETIRE_W = 16,
    parameter int CAUSE_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    instr_sequencer_if.slave  bus
);
    localparam int                CNT_W     = $clog2(ALU_LAT + 1);
    localparam logic [CNT_W-1:0]  EXEC_LOAD = CNT_W'(ALU_LAT - 1);

    logic [STATE_W-1:0]  r_state;
    logic [INSTR_W-1:0]  r_ir;
    logic [RETIRE_W-1:0] r_retired;
    logic [CAUSE_W-1:0]  r_cause;

    logic [STATE_W-1:0]  w_state_nxt;
    logic [CAUSE_W-1:0]  w_cause_nxt;
    logic                w_fetch_go;
    logic                w_cnt_load;
    logic                w_cnt_dec;
    logic                w_cnt_zero;

    // Instruction is accepted in FETCH once it is present and not faulting
    assign w_fetch_go = (r_state == ST_FETCH) && !bus.instr_segv && !bus.wait_instr;

    // The EXEC timer is armed on the DECODE cycle that dispatches an ALU op
    assign w_cnt_load = (r_state == ST_DECODE) && !bus.dec_invalid && r_ir[IS_ALU_BIT];
    assign w_cnt_dec  = (r_state == ST_EXEC);

    seq_latency_counter #(
        .W (CNT_W)
    ) u_exec_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_cnt_load),
        .i_load_val (EXEC_LOAD),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // Next state and fault cause from the current state and the flags it samples
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        case (r_state)
            ST_FETCH: begin
                if (bus.instr_segv) begin
                    w_state_nxt = ST_FAULT;
                    w_cause_nxt = CAUSE_W'(CAUSE_ISEGV);
                end else if (!bus.wait_instr) begin
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (bus.dec_invalid) begin
                    w_state_nxt = ST_FAULT;
                    w_cause_nxt = CAUSE_W'(CAUSE_ILL);
                end else if (r_ir[IS_ALU_BIT]) begin
                    w_state_nxt = ST_EXEC;
                end else if (bus.dec_mem) begin
                    w_state_nxt = ST_MEM;
                end else begin
                    w_state_nxt = ST_RETIRE;
                end
            end
            ST_EXEC: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_RETIRE;
                end
            end
            ST_MEM: begin
                if (bus.data_segv) begin
                    w_state_nxt = ST_FAULT;
                    w_cause_nxt = CAUSE_W'(CAUSE_DSEGV);
                end else if (!bus.wait_data) begin
                    w_state_nxt = ST_RETIRE;
                end
            end
            ST_RETIRE: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FAULT: begin
                if (bus.fault_clear) begin
                    w_state_nxt = ST_FETCH;
                    w_cause_nxt = CAUSE_W'(CAUSE_NONE);
                end
            end
            default: begin
                w_state_nxt = ST_FETCH;
                w_cause_nxt = CAUSE_W'(CAUSE_NONE);
            end
        endcase
    end

    // State, IR, fault cause and retire count; reset aborts any op in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_FETCH;
            r_ir      <= '0;
            r_retired <= '0;
            r_cause   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cause <= w_cause_nxt;
            if (w_fetch_go) begin
                r_ir <= bus.instruction;
            end
            if (r_state == ST_RETIRE) begin
                r_retired <= r_retired + RETIRE_W'(1);
            end
        end
    end

    // ir_load coincides with the capture edge so the IR and external latches agree;
    // it is suppressed while reset is held because the capture is discarded then.
    assign bus.ir_load     = w_fetch_go && !reset;
    assign bus.exec_en     = (r_state == ST_EXEC) && w_cnt_zero;
    assign bus.mem_req     = (r_state == ST_MEM);
    assign bus.pc_inc      = (r_state == ST_RETIRE);
    assign bus.fault       = (r_state == ST_FAULT);
    assign bus.fault_cause = r_cause;
    assign bus.ir          = r_ir;
    assign bus.retired     = r_retired;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer. Stimulus plays whole instructions
// (kind, fetch waits, data waits, fault hold) and pushes the expected outcome
// of each into a scoreboard; a monitor pops one entry per retire or fault.
module tb_instr_sequencer;

    localparam int INSTR_W  = 32;
    localparam int ALU_LAT  = 3;
    localparam int RETIRE_W = 4;   // narrow counter so wrap-around happens often
    localparam int CAUSE_W  = 2;

    localparam int K_PC = 0, K_ALU = 1, K_MEM = 2, K_ISEGV = 3, K_INV = 4, K_DSEGV = 5;

    typedef struct {
        bit          is_fault;
        logic [31:0] ir;
        int          retired;
        int          cause;
        int          n_ld;
        int          n_ex;
        int          n_mem;
        int          n_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    instr_sequencer_if #(
        .INSTR_W  (INSTR_W),
        .RETIRE_W (RETIRE_W),
        .CAUSE_W  (CAUSE_W)
    ) bus ();

    instr_sequencer #(
        .INSTR_W  (INSTR_W),
        .ALU_LAT  (ALU_LAT),
        .RETIRE_W (RETIRE_W),
        .CAUSE_W  (CAUSE_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    int          n_vec  = 0;
    int          n_fail = 0;
    int          m_retired = 0;
    logic [31:0] m_ir = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Random values on every input; callers then pin the ones the current phase samples
    task automatic noise();
        bus.instruction = $urandom;
        bus.instr_segv  = 1'($urandom);
        bus.wait_instr  = 1'($urandom);
        bus.data_segv   = 1'($urandom);
        bus.wait_data   = 1'($urandom);
        bus.dec_invalid = 1'($urandom);
        bus.dec_mem     = 1'($urandom);
        bus.fault_clear = 1'($urandom);
    endtask

    task automatic run_txn(input int kind, input int wi, input int wd, input int hold,
                           input logic [31:0] word_in);
        logic [31:0] w;
        exp_t        e;
        bit          flt;
        w = word_in;
        if (kind == K_ALU) w[0] = 1'b1;
        if (kind == K_PC || kind == K_MEM || kind == K_DSEGV) w[0] = 1'b0;
        flt = (kind == K_ISEGV) || (kind == K_INV) || (kind == K_DSEGV);

        e.is_fault = flt;
        e.ir       = (kind == K_ISEGV) ? m_ir : w;
        e.retired  = m_retired;
        e.cause    = (kind == K_ISEGV) ? 1 : (kind == K_DSEGV) ? 2 : (kind == K_INV) ? 3 : 0;
        e.n_ld     = (kind == K_ISEGV) ? 0 : 1;
        e.n_ex     = (kind == K_ALU) ? 1 : 0;
        e.n_mem    = (kind == K_MEM || kind == K_DSEGV) ? wd + 1 : 0;
        case (kind)
            K_PC:    e.n_cyc = wi + 3;
            K_ALU:   e.n_cyc = wi + 3 + ALU_LAT;
            K_MEM:   e.n_cyc = wi + wd + 4;
            K_ISEGV: e.n_cyc = wi + 2;
            K_INV:   e.n_cyc = wi + 3;
            default: e.n_cyc = wi + wd + 4;
        endcase
        sb.push_back(e);
        if (kind != K_ISEGV) m_ir = w;
        if (!flt) m_retired = (m_retired + 1) % (1 << RETIRE_W);

        for (int i = 0; i < wi; i++) begin
            noise(); bus.instr_segv = 1'b0; bus.wait_instr = 1'b1; step();
        end
        noise();
        if (kind == K_ISEGV) begin
            bus.instr_segv = 1'b1;
        end else begin
            bus.instr_segv = 1'b0; bus.wait_instr = 1'b0; bus.instruction = w;
        end
        step();
        if (kind != K_ISEGV) begin
            noise();
            bus.dec_invalid = (kind == K_INV);
            if (kind != K_ALU && kind != K_INV) bus.dec_mem = (kind == K_MEM || kind == K_DSEGV);
            step();
            if (kind == K_ALU) begin
                for (int i = 0; i < ALU_LAT; i++) begin noise(); step(); end
            end
            if (kind == K_MEM || kind == K_DSEGV) begin
                for (int i = 0; i < wd; i++) begin
                    noise(); bus.data_segv = 1'b0; bus.wait_data = 1'b1; step();
                end
                noise();
                if (kind == K_DSEGV) bus.data_segv = 1'b1;
                else begin bus.data_segv = 1'b0; bus.wait_data = 1'b0; end
                step();
            end
            if (!flt) begin noise(); step(); end
        end
        if (flt) begin
            for (int i = 0; i < hold; i++) begin noise(); bus.fault_clear = 1'b0; step(); end
            noise(); bus.fault_clear = 1'b1; step();
        end
    endtask

    // Memory op interrupted by reset while waiting for data; nothing may retire
    task automatic abort_mem();
        noise(); bus.instr_segv = 1'b0; bus.wait_instr = 1'b0; bus.instruction = $urandom & ~32'h1; step();
        noise(); bus.dec_invalid = 1'b0; bus.dec_mem = 1'b1; step();
        for (int i = 0; i < 2; i++) begin
            noise(); bus.data_segv = 1'b0; bus.wait_data = 1'b1; step();
        end
        noise(); reset = 1'b1; step();
        reset = 1'b0;
        m_retired = 0;
        m_ir = '0;
    endtask

    // Monitor: accumulates per-instruction activity and scores it at retire/fault
    initial begin
        int   cyc = 0, nld = 0, nex = 0, nmem = 0, held_cause = 0;
        bit   prev_fault = 1'b0, rst_pending = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_pending) begin
                check("rst_ir", bus.ir, 32'h0);
                check("rst_retired", 32'(bus.retired), 32'h0);
                check("rst_cause", 32'(bus.fault_cause), 32'h0);
                check("rst_pulses", {28'h0, bus.exec_en, bus.mem_req, bus.pc_inc, bus.fault}, 32'h0);
                cyc = 0; nld = 0; nex = 0; nmem = 0; prev_fault = 1'b0;
            end
            if (bus.fault && prev_fault) begin
                check("fault_cause_held", 32'(bus.fault_cause), 32'(held_cause));
                check("fault_pulses", {28'h0, bus.ir_load, bus.exec_en, bus.mem_req, bus.pc_inc}, 32'h0);
            end else begin
                cyc++;
                nld  += int'(bus.ir_load);
                nex  += int'(bus.exec_en);
                nmem += int'(bus.mem_req);
                if (bus.pc_inc || bus.fault) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_end: pc_inc=%0b fault=%0b with empty scoreboard at %0t",
                                 bus.pc_inc, bus.fault, $time);
                    end else begin
                        e = sb.pop_front();
                        check("end_is_fault", {31'h0, bus.fault}, {31'h0, e.is_fault});
                        check("end_pc_inc", {31'h0, bus.pc_inc}, {31'h0, !e.is_fault});
                        check("ir", bus.ir, e.ir);
                        check("retired", 32'(bus.retired), 32'(e.retired));
                        check("fault_cause", 32'(bus.fault_cause), 32'(e.cause));
                        check("ir_load_count", 32'(nld), 32'(e.n_ld));
                        check("exec_en_count", 32'(nex), 32'(e.n_ex));
                        check("mem_req_count", 32'(nmem), 32'(e.n_mem));
                        check("latency", 32'(cyc), 32'(e.n_cyc));
                        held_cause = e.cause;
                    end
                    cyc = 0; nld = 0; nex = 0; nmem = 0;
                end
            end
            prev_fault  = bus.fault;
            rst_pending = reset;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Stimulus: directed scenarios first, then random instruction mix
    initial begin
        int waited;
        reset = 1'b1;
        bus.instruction = '0; bus.instr_segv = 1'b0; bus.wait_instr = 1'b0;
        bus.data_segv = 1'b0; bus.wait_data = 1'b0; bus.dec_invalid = 1'b0;
        bus.dec_mem = 1'b0; bus.fault_clear = 1'b0;
        step(); step();
        reset = 1'b0;

        run_txn(K_ALU,   0, 0, 0, 32'h0000_0001);
        run_txn(K_PC,    4, 0, 0, 32'h0000_0002);
        run_txn(K_MEM,   0, 3, 0, 32'h0000_0000);
        run_txn(K_ISEGV, 2, 0, 2, 32'h0);
        run_txn(K_INV,   0, 0, 1, 32'hDEAD_BEEF);
        run_txn(K_DSEGV, 1, 2, 0, 32'h1234_5670);
        abort_mem();
        for (int i = 0; i < 17; i++) run_txn(K_PC, 0, 0, 0, $urandom);
        for (int i = 0; i < 150; i++) begin
            run_txn(int'($urandom_range(0, 5)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), $urandom);
        end

        waited = 0;
        while (sb.size() != 0 && waited < 20) begin
            noise(); bus.instr_segv = 1'b0; bus.wait_instr = 1'b1; step();
            waited++;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
